// File: rtl/i2c_regbank.sv
// I2C slave register bank: byte-pointer addressed RW and RO 32-bit words.
// Ports: clk/rst_n; start/stop/data_vld/r_w/wr_data from the I2C slave
// front end; rd_data is the next byte for a master read; ro_regs in,
// rw_regs/wr_strobe out; addr_err flags bad accesses since last start.
module i2c_regbank #(
    parameter int                 N_RW       = 16,
    parameter int                 N_RO       = 8,
    parameter int                 RO_BASE_W  = 32,
    parameter logic [N_RW*32-1:0] RW_RESET   = '0,
    parameter logic [N_RW-1:0]    PULSE_MASK = '0,
    parameter int                 PULSE_LEN  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               data_vld,
    input  logic               r_w,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_data,
    input  logic [N_RO*32-1:0] ro_regs,
    output logic [N_RW*32-1:0] rw_regs,
    output logic [N_RW-1:0]    wr_strobe,
    output logic               addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  ptr, ptr_nxt;
    logic        ptr_mv, ptr_moved;
    logic        wr_acc, err_set;
    logic [23:0] stage;
    logic [2:0]  lane_wr;
    logic [31:0] snapshot;
    logic [5:0]  snap_word;
    logic [7:0]  pcnt [N_RW];

    logic [31:0] cur_word;
    logic [31:0] commit_word;
    logic        hit_rw, hit_ro, mapped, commit;

    // Word currently addressed by ptr; unmapped words read as zero.
    always_comb begin
        cur_word = '0;
        hit_rw   = 1'b0;
        hit_ro   = 1'b0;
        for (int k = 0; k < N_RW; k++) begin
            if (ptr[7:2] == 6'(k)) begin
                cur_word = rw_regs[k*32 +: 32];
                hit_rw   = 1'b1;
            end
        end
        for (int k = 0; k < N_RO; k++) begin
            if (ptr[7:2] == 6'(RO_BASE_W + k)) begin
                cur_word = ro_regs[k*32 +: 32];
                hit_ro   = 1'b1;
            end
        end
    end

    assign mapped = hit_rw | hit_ro;

    // Lane 3 completes the word; lanes never staged keep the live value.
    always_comb begin
        commit_word = {wr_data, cur_word[23:0]};
        for (int i = 0; i < 3; i++) begin
            if (lane_wr[i]) commit_word[i*8 +: 8] = stage[i*8 +: 8];
        end
    end

    assign commit = wr_acc & hit_rw & (ptr[1:0] == 2'd3);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ptr_mv    = 1'b0;
        wr_acc    = 1'b0;
        err_set   = 1'b0;
        if (start || stop) begin
            state_nxt = IDLE;
        end else if (data_vld) begin
            unique case (state)
                IDLE: begin
                    ptr_mv = 1'b1;
                    if (!r_w) begin
                        ptr_nxt   = wr_data;
                        state_nxt = WRITE;
                    end else begin
                        ptr_nxt   = ptr + 8'd1;
                        state_nxt = READ;
                        err_set   = ~mapped;
                    end
                end
                WRITE: begin
                    if (!r_w) begin
                        ptr_nxt = ptr + 8'd1;
                        ptr_mv  = 1'b1;
                        wr_acc  = 1'b1;
                        err_set = ~hit_rw;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                READ: begin
                    if (r_w) begin
                        ptr_nxt = ptr + 8'd1;
                        ptr_mv  = 1'b1;
                        err_set = ~mapped;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            ptr_moved <= 1'b0;
            addr_err  <= 1'b0;
            stage     <= '0;
            lane_wr   <= '0;
            snapshot  <= '0;
            snap_word <= '0;
            rd_data   <= '0;
            rw_regs   <= RW_RESET;
            wr_strobe <= '0;
            pcnt      <= '{default: '0};
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            ptr_moved <= ptr_mv;
            wr_strobe <= '0;

            if (start) addr_err <= 1'b0;
            else if (err_set) addr_err <= 1'b1;

            // Partial words die with the transaction.
            if (start || stop) begin
                stage   <= '0;
                lane_wr <= '0;
            end else if (wr_acc && hit_rw) begin
                if (ptr[1:0] == 2'd3) begin
                    stage   <= '0;
                    lane_wr <= '0;
                end else begin
                    stage[{ptr[1:0], 3'b000} +: 8] <= wr_data;
                    lane_wr[ptr[1:0]]              <= 1'b1;
                end
            end

            for (int k = 0; k < N_RW; k++) begin
                if (commit && ptr[7:2] == 6'(k)) begin
                    rw_regs[k*32 +: 32] <= commit_word;
                    wr_strobe[k]        <= 1'b1;
                    pcnt[k] <= PULSE_MASK[k] ? 8'(PULSE_LEN) : 8'd0;
                end else if (pcnt[k] != 8'd0) begin
                    pcnt[k] <= pcnt[k] - 8'd1;
                    if (pcnt[k] == 8'd1) rw_regs[k*32 +: 32] <= '0;
                end
            end

            // Re-snapshot only when the pointer lands on a fresh word
            // or wraps to lane 0, so a multi-byte read stays coherent.
            if (ptr_moved &&
                (ptr[1:0] == 2'd0 || ptr[7:2] != snap_word)) begin
                snapshot  <= cur_word;
                snap_word <= ptr[7:2];
            end

            rd_data <= snapshot[{ptr[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_i2c_regbank.sv
// Directed self-checking bench for i2c_regbank.
// Word0/4/5 have non-zero reset values; word2 self-clears.
module tb_i2c_regbank;

    localparam logic [511:0] RST_VAL =
        (512'h04030201) |
        (512'h44444444 << 128) |
        (512'hA5A50005 << 160);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, data_vld, r_w;
    logic [7:0]   wr_data;
    logic [7:0]   rd_data;
    logic [255:0] ro_regs;
    logic [511:0] rw_regs;
    logic [15:0]  wr_strobe;
    logic         addr_err;

    int n_chk = 0;
    int n_fail = 0;
    int strb_cnt [16];

    i2c_regbank #(
        .N_RW(16), .N_RO(8), .RO_BASE_W(32),
        .RW_RESET(RST_VAL),
        .PULSE_MASK(16'h0004),
        .PULSE_LEN(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .stop(stop),
        .data_vld(data_vld), .r_w(r_w),
        .wr_data(wr_data), .rd_data(rd_data),
        .ro_regs(ro_regs), .rw_regs(rw_regs),
        .wr_strobe(wr_strobe), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial foreach (strb_cnt[k]) strb_cnt[k] = 0;

    always @(negedge clk)
        for (int k = 0; k < 16; k++)
            if (wr_strobe[k] === 1'b1) strb_cnt[k]++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic send(input logic dir, input logic [7:0] d);
        @(negedge clk);
        data_vld = 1'b1;
        r_w      = dir;
        wr_data  = d;
        @(negedge clk);
        data_vld = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b);
        tick(2);
        b = rd_data;
        send(1'b1, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_chk++;
        if (rw_regs !== RST_VAL) begin
            n_fail++;
            $display("FAIL rst_rw got %h want %h", rw_regs, RST_VAL);
        end
        n_chk++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_rd got %h want 00", rd_data);
        end
        n_chk++;
        if (wr_strobe !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_strb got %h want 0", wr_strobe);
        end
        n_chk++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err got %b want 0", addr_err);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write_commit();
        int base;
        base = strb_cnt[4];
        do_start();
        send(1'b0, 8'h10);
        send(1'b0, 8'hEF);
        send(1'b0, 8'hBE);
        send(1'b0, 8'hAD);
        n_chk++;
        if (rw_regs[128 +: 32] !== 32'h44444444) begin
            n_fail++;
            $display("FAIL wr_early got %h want 44444444",
                     rw_regs[128 +: 32]);
        end
        send(1'b0, 8'hDE);
        n_chk++;
        if (rw_regs[128 +: 32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_word4 got %h want DEADBEEF",
                     rw_regs[128 +: 32]);
        end
        n_chk++;
        if (wr_strobe !== 16'h0010) begin
            n_fail++;
            $display("FAIL wr_strb got %h want 0010", wr_strobe);
        end
        tick(1);
        n_chk++;
        if (wr_strobe !== 16'h0000) begin
            n_fail++;
            $display("FAIL wr_strb_off got %h want 0000", wr_strobe);
        end
        do_stop();
        tick(2);
        n_chk++;
        if (strb_cnt[4] - base !== 1) begin
            n_fail++;
            $display("FAIL wr_strb_cnt got %0d want 1",
                     strb_cnt[4] - base);
        end
    endtask

    task automatic test_partial();
        int base;
        base = strb_cnt[4];
        do_start();
        send(1'b0, 8'h10);
        send(1'b0, 8'h11);
        do_stop();
        tick(2);
        n_chk++;
        if (rw_regs[128 +: 32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL part_word4 got %h want DEADBEEF",
                     rw_regs[128 +: 32]);
        end
        n_chk++;
        if (strb_cnt[4] - base !== 0) begin
            n_fail++;
            $display("FAIL part_strb got %0d want 0",
                     strb_cnt[4] - base);
        end
        do_start();
        send(1'b0, 8'h11);
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        send(1'b0, 8'hCC);
        n_chk++;
        if (rw_regs[128 +: 32] !== 32'hCCBBAAEF) begin
            n_fail++;
            $display("FAIL merge_word4 got %h want CCBBAAEF",
                     rw_regs[128 +: 32]);
        end
        do_stop();
    endtask

    task automatic test_dir_err();
        do_start();
        send(1'b0, 8'h10);
        send(1'b1, 8'h99);
        n_chk++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_err got %b want 1", addr_err);
        end
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h04);
        n_chk++;
        if (rw_regs[128 +: 32] !== 32'h04030201) begin
            n_fail++;
            $display("FAIL dir_word4 got %h want 04030201",
                     rw_regs[128 +: 32]);
        end
        do_start();
        n_chk++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_clr got %b want 0", addr_err);
        end
        send(1'b0, 8'h80);
        send(1'b0, 8'h55);
        n_chk++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ro_wr_err got %b want 1", addr_err);
        end
        do_stop();
    endtask

    task automatic test_ro_read();
        logic [7:0] b;
        logic [7:0] exp_b [5];
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0};
        ro_regs[31:0]  = 32'h12345678;
        ro_regs[63:32] = 32'h9ABCDEF0;
        do_start();
        send(1'b0, 8'h80);
        do_start();
        for (int i = 0; i < 5; i++) begin
            read_byte(b);
            if (i == 0) ro_regs[31:0] = 32'hFFFFFFFF;
            n_chk++;
            if (b !== exp_b[i]) begin
                n_fail++;
                $display("FAIL ro_rd%0d got %h want %h",
                         i, b, exp_b[i]);
            end
        end
        n_chk++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ro_rd_err got %b want 0", addr_err);
        end
        do_stop();
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        do_start();
        send(1'b0, 8'hFF);
        do_start();
        read_byte(b);
        n_chk++;
        if (b !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_rd0 got %h want 00", b);
        end
        n_chk++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_err got %b want 1", addr_err);
        end
        read_byte(b);
        n_chk++;
        if (b !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_rd1 got %h want 01", b);
        end
        n_chk++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_sticky got %b want 1", addr_err);
        end
        do_start();
        n_chk++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_clr got %b want 0", addr_err);
        end
        do_stop();
    endtask

    task automatic test_pulse();
        logic [31:0] exp_w [4];
        exp_w = '{32'h1, 32'h1, 32'h1, 32'h0};
        do_start();
        send(1'b0, 8'h08);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        n_chk++;
        if (wr_strobe !== 16'h0004) begin
            n_fail++;
            $display("FAIL pulse_strb got %h want 0004", wr_strobe);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rw_regs[64 +: 32] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL pulse_c%0d got %h want %h",
                         i, rw_regs[64 +: 32], exp_w[i]);
            end
            tick(1);
        end
        do_stop();
    endtask

    task automatic test_start_wins();
        int base;
        base = strb_cnt[5];
        do_start();
        send(1'b0, 8'h14);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        @(negedge clk);
        start    = 1'b1;
        data_vld = 1'b1;
        r_w      = 1'b0;
        wr_data  = 8'h44;
        @(negedge clk);
        start    = 1'b0;
        data_vld = 1'b0;
        tick(2);
        n_chk++;
        if (rw_regs[160 +: 32] !== 32'hA5A50005) begin
            n_fail++;
            $display("FAIL sw_word5 got %h want A5A50005",
                     rw_regs[160 +: 32]);
        end
        n_chk++;
        if (strb_cnt[5] - base !== 0) begin
            n_fail++;
            $display("FAIL sw_strb got %0d want 0",
                     strb_cnt[5] - base);
        end
        do_stop();
    endtask

    task automatic test_reset_mid();
        int base;
        base = strb_cnt[5];
        do_start();
        send(1'b0, 8'h14);
        send(1'b0, 8'hA1);
        send(1'b0, 8'hA2);
        @(negedge clk);
        data_vld = 1'b1;
        r_w      = 1'b0;
        wr_data  = 8'hA3;
        rst_n    = 1'b0;
        @(negedge clk);
        data_vld = 1'b0;
        n_chk++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rm_rd got %h want 00", rd_data);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        n_chk++;
        if (rw_regs[160 +: 32] !== 32'hA5A50005) begin
            n_fail++;
            $display("FAIL rm_word5 got %h want A5A50005",
                     rw_regs[160 +: 32]);
        end
        n_chk++;
        if (strb_cnt[5] - base !== 0) begin
            n_fail++;
            $display("FAIL rm_strb got %0d want 0",
                     strb_cnt[5] - base);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        data_vld = 1'b0;
        r_w      = 1'b0;
        wr_data  = 8'h00;
        ro_regs  = '0;
        test_reset();
        test_write_commit();
        test_partial();
        test_dir_err();
        test_ro_read();
        test_wrap();
        test_pulse();
        test_start_wins();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
